tlb_array_ctrl: RTL and testbench

- Owns the TLB entry storage and executes the TLB maintenance instructions: TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB.
- Drives the registered entry array consumed combinationally by the TLB lookup stage that translates fetch and load/store addresses.
- Sits beside the CSR unit. The EX/MEM stage issues one maintenance request at a time through a valid/ready handshake.
- INVTLB walks the array one entry per cycle, so the block is multi-cycle.

---
 rtl/tlb_array_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_tlb_array_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_array_ctrl.sv
// TLB entry storage plus TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB sequencer.
// Optional define TLB_FILL_LFSR_EN selects an LFSR FILL index instead of round-robin.
package tlb_array_ctrl_pkg;
  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;
endpackage

// Per-entry compare: search hit and INVTLB clear decision for one slot.
module tlb_entry_cmp (
  input  logic [18:0] i_e_vppn,
  input  logic [5:0]  i_e_ps,
  input  logic        i_e_g,
  input  logic [9:0]  i_e_asid,
  input  logic        i_e_e,
  input  logic [9:0]  i_asid,
  input  logic [18:0] i_vppn,
  input  logic [4:0]  i_inv_op,
  output logic        o_srch_hit,
  output logic        o_inv_clr
);
  logic w_asid_eq;
  logic w_va_eq;

  assign w_asid_eq  = (i_e_asid == i_asid);
  // 2MB pages (ps=21) ignore the low 9 VPPN bits
  assign w_va_eq    = (i_e_ps == 6'd21) ? (i_e_vppn[18:9] == i_vppn[18:9])
                                        : (i_e_vppn == i_vppn);
  assign o_srch_hit = i_e_e && (i_e_g || w_asid_eq) && w_va_eq;

  always_comb begin
    o_inv_clr = 1'b0;
    case (i_inv_op)
      5'd0, 5'd1: o_inv_clr = 1'b1;
      5'd2:       o_inv_clr = i_e_g;
      5'd3:       o_inv_clr = !i_e_g;
      5'd4:       o_inv_clr = !i_e_g && w_asid_eq;
      5'd5:       o_inv_clr = !i_e_g && w_asid_eq && w_va_eq;
      5'd6:       o_inv_clr = (i_e_g || w_asid_eq) && w_va_eq;
      default:    o_inv_clr = 1'b0;
    endcase
  end
endmodule

module tlb_array_ctrl
  import tlb_array_ctrl_pkg::*;
#(
  parameter int TLB_ENTRY_NUM = 16,
  parameter int IDX_W         = $clog2(TLB_ENTRY_NUM)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [2:0]                          req_op,
  input  logic [IDX_W-1:0]                    req_idx,
  input  tlb_entry_t                          req_entry,
  input  logic [9:0]                          req_asid,
  input  logic [18:0]                         req_vppn,
  input  logic [4:0]                          req_inv_op,
  output logic                                resp_valid,
  output logic                                resp_hit,
  output logic [IDX_W-1:0]                    resp_idx,
  output tlb_entry_t                          resp_entry,
  output logic                                resp_inv_err,
  output tlb_entry_t [TLB_ENTRY_NUM-1:0]      entrys
);
  typedef enum logic [1:0] {S_IDLE, S_SRCH, S_INV, S_RESP} state_t;

  state_t                           r_state, w_state_nxt;
  tlb_entry_t [TLB_ENTRY_NUM-1:0]   r_entrys;
  logic [9:0]                       r_asid;
  logic [18:0]                      r_vppn;
  logic [4:0]                       r_inv_op;
  logic [IDX_W-1:0]                 r_cnt;
  logic                             r_resp_hit;
  logic [IDX_W-1:0]                 r_resp_idx;
  tlb_entry_t                       r_resp_entry;
  logic                             r_resp_inv_err;

  logic [TLB_ENTRY_NUM-1:0]         w_srch_hit;
  logic [TLB_ENTRY_NUM-1:0]         w_inv_clr;
  logic                             w_accept;
  logic                             w_inv_illegal;
  logic                             w_last;
  logic                             w_hit;
  logic [IDX_W-1:0]                 w_hit_idx;
  logic [IDX_W-1:0]                 w_fill_idx;

  assign w_accept      = req_valid && (r_state == S_IDLE);
  assign w_inv_illegal = (req_inv_op > 5'd6);
  assign w_last        = (r_cnt == IDX_W'(TLB_ENTRY_NUM - 1));

  genvar g;
  generate
    for (g = 0; g < TLB_ENTRY_NUM; g++) begin : g_cmp
      tlb_entry_cmp u_cmp (
        .i_e_vppn   (r_entrys[g].vppn),
        .i_e_ps     (r_entrys[g].ps),
        .i_e_g      (r_entrys[g].g),
        .i_e_asid   (r_entrys[g].asid),
        .i_e_e      (r_entrys[g].e),
        .i_asid     (r_asid),
        .i_vppn     (r_vppn),
        .i_inv_op   (r_inv_op),
        .o_srch_hit (w_srch_hit[g]),
        .o_inv_clr  (w_inv_clr[g])
      );
    end
  endgenerate

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    w_hit     = |w_srch_hit;
    w_hit_idx = '0;
    for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
      if (w_srch_hit[i]) w_hit_idx = IDX_W'(i);
    end
  end

`ifdef TLB_FILL_LFSR_EN
  logic [15:0] r_lfsr;
  assign w_fill_idx = r_lfsr[IDX_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lfsr <= 16'hACE1;
    else if (w_accept && req_op == OP_FILL)
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
`else
  logic [IDX_W-1:0] r_fill_ptr;
  assign w_fill_idx = r_fill_ptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fill_ptr <= '0;
    else if (w_accept && req_op == OP_FILL)
      r_fill_ptr <= r_fill_ptr + 1'b1;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (req_op == OP_SRCH)                       w_state_nxt = S_SRCH;
          else if (req_op == OP_INV && !w_inv_illegal) w_state_nxt = S_INV;
          else                                         w_state_nxt = S_RESP;
        end
      end
      S_SRCH:  w_state_nxt = S_RESP;
      S_INV:   if (w_last) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asid   <= '0;
      r_vppn   <= '0;
      r_inv_op <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_asid   <= req_asid;
      r_vppn   <= req_vppn;
      r_inv_op <= req_inv_op;
      r_cnt    <= '0;
    end else if (r_state == S_INV) begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Accept (IDLE) and walk (INV) are mutually exclusive writers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entrys <= '0;
    end else begin
      if (w_accept && req_op == OP_WR)   r_entrys[req_idx]    <= req_entry;
      if (w_accept && req_op == OP_FILL) r_entrys[w_fill_idx] <= req_entry;
      if (r_state == S_INV && w_inv_clr[r_cnt]) r_entrys[r_cnt].e <= 1'b0;
    end
  end

  // Response fields update only on the edge that enters RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_hit     <= 1'b0;
      r_resp_idx     <= '0;
      r_resp_entry   <= '0;
      r_resp_inv_err <= 1'b0;
    end else if (w_accept) begin
      case (req_op)
        OP_SRCH: ;
        OP_RD: begin
          r_resp_entry   <= r_entrys[req_idx].e ? r_entrys[req_idx] : '0;
          r_resp_inv_err <= 1'b0;
        end
        OP_INV:  if (w_inv_illegal) r_resp_inv_err <= 1'b1;
        default: r_resp_inv_err <= 1'b0;
      endcase
    end else if (r_state == S_SRCH) begin
      r_resp_hit     <= w_hit;
      r_resp_idx     <= w_hit_idx;
      r_resp_inv_err <= 1'b0;
    end else if (r_state == S_INV && w_last) begin
      r_resp_inv_err <= 1'b0;
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign resp_valid   = (r_state == S_RESP);
  assign resp_hit     = r_resp_hit;
  assign resp_idx     = r_resp_idx;
  assign resp_entry   = r_resp_entry;
  assign resp_inv_err = r_resp_inv_err;
  assign entrys       = r_entrys;
endmodule

// File: tb/tb_tlb_array_ctrl.sv
// Self-checking bench for tlb_array_ctrl: directed scenarios plus random ops
// checked against an array-level reference model.
module tb_tlb_array_ctrl;
  import tlb_array_ctrl_pkg::*;
  localparam int N  = 16;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready;
  logic [2:0] req_op;
  logic [IW-1:0] req_idx;
  tlb_entry_t req_entry;
  logic [9:0] req_asid;
  logic [18:0] req_vppn;
  logic [4:0] req_inv_op;
  logic resp_valid, resp_hit, resp_inv_err;
  logic [IW-1:0] resp_idx;
  tlb_entry_t resp_entry;
  tlb_entry_t [N-1:0] entrys;

  tlb_array_ctrl #(.TLB_ENTRY_NUM(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_idx(req_idx), .req_entry(req_entry), .req_asid(req_asid),
    .req_vppn(req_vppn), .req_inv_op(req_inv_op), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_idx(resp_idx), .resp_entry(resp_entry),
    .resp_inv_err(resp_inv_err), .entrys(entrys)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  tlb_entry_t mdl [N];
  int         fill_mdl;
  logic [15:0] lfsr_mdl;
  logic       exp_hit;
  logic [IW-1:0] exp_idx;
  tlb_entry_t exp_entry;
  logic       exp_err;
  int         exp_lat;

  function automatic bit va_match(tlb_entry_t t, logic [18:0] v);
    if (t.ps == 6'd21) return t.vppn[18:9] == v[18:9];
    return t.vppn == v;
  endfunction

  function automatic bit inv_clears(tlb_entry_t t, int op, logic [9:0] a, logic [18:0] v);
    bit am = (t.asid == a);
    bit vm = va_match(t, v);
    case (op)
      0, 1: return 1'b1;
      2: return t.g;
      3: return !t.g;
      4: return !t.g && am;
      5: return !t.g && am && vm;
      6: return (t.g || am) && vm;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int arr_diff();
    for (int i = 0; i < N; i++) if (entrys[i] !== mdl[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mdl[i] = '0;
    fill_mdl = 0;
    lfsr_mdl = 16'hACE1;
  endtask

  task automatic fill_take(output int fi);
`ifdef TLB_FILL_LFSR_EN
    fi = int'(lfsr_mdl) % N;
    lfsr_mdl = {lfsr_mdl[14:0], lfsr_mdl[15] ^ lfsr_mdl[13] ^ lfsr_mdl[12] ^ lfsr_mdl[10]};
`else
    fi = fill_mdl;
    fill_mdl = (fill_mdl + 1) % N;
`endif
  endtask

  task automatic model_op(input logic [2:0] op, input logic [IW-1:0] idx, input tlb_entry_t ent,
                          input logic [9:0] asid, input logic [18:0] vppn, input logic [4:0] inv);
    int fi;
    exp_err = 1'b0;
    exp_lat = 1;
    case (op)
      OP_RD:   exp_entry = mdl[idx].e ? mdl[idx] : '0;
      OP_WR:   mdl[idx] = ent;
      OP_FILL: begin fill_take(fi); mdl[fi] = ent; end
      OP_SRCH: begin
        exp_lat = 2; exp_hit = 1'b0; exp_idx = '0;
        for (int i = 0; i < N; i++)
          if (!exp_hit && mdl[i].e && (mdl[i].g || mdl[i].asid == asid) && va_match(mdl[i], vppn)) begin
            exp_hit = 1'b1; exp_idx = IW'(i);
          end
      end
      OP_INV: begin
        if (inv > 5'd6) exp_err = 1'b1;
        else begin
          exp_lat = N + 1;
          for (int i = 0; i < N; i++) if (inv_clears(mdl[i], int'(inv), asid, vppn)) mdl[i].e = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic do_req(input logic [2:0] op, input logic [IW-1:0] idx, input tlb_entry_t ent,
                        input logic [9:0] asid, input logic [18:0] vppn, input logic [4:0] inv,
                        output int lat, output logic rdy);
    @(negedge clk);
    rdy = req_ready;
    req_valid = 1'b1; req_op = op; req_idx = idx; req_entry = ent;
    req_asid = asid; req_vppn = vppn; req_inv_op = inv;
    @(negedge clk);
    req_valid = 1'b0;
    req_entry = '0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
    model_op(op, idx, ent, asid, vppn, inv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic tlb_entry_t mk(logic [18:0] v, logic [9:0] a, logic [5:0] ps, logic g, logic e);
    tlb_entry_t t = '0;
    t.vppn = v; t.asid = a; t.ps = ps; t.g = g; t.e = e;
    t.ppn0 = 20'($urandom); t.ppn1 = 20'($urandom); t.v0 = 1'b1; t.mat1 = 2'd1;
    return t;
  endfunction

  function automatic tlb_entry_t rand_entry();
    logic [18:0] v;
    case ($urandom_range(0, 3))
      0: v = 19'h12345;
      1: v = 19'h12200;
      2: v = 19'h123FF;
      default: v = 19'($urandom);
    endcase
    return mk(v, ($urandom_range(0, 1) != 0) ? 10'd5 : 10'd6,
              ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12,
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0);
  endfunction

  int lat; logic rdy; int d; tlb_entry_t ew;

  task automatic test_reset();
    do_reset();
    n_tests++; if (entrys !== '0) begin n_fail++; $display("FAIL reset_entrys: entry 0 got %h required 0", entrys[0]); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    n_tests++; if ({resp_valid, resp_hit, resp_idx, resp_inv_err} !== '0 || resp_entry !== '0) begin
      n_fail++; $display("FAIL reset_resp: valid %b hit %b idx %0d err %b required all 0", resp_valid, resp_hit, resp_idx, resp_inv_err); end
  endtask

  task automatic test_wr();
    ew = mk(19'h12345, 10'd5, 6'd12, 1'b0, 1'b1);
    do_req(OP_WR, IW'(3), ew, '0, '0, '0, lat, rdy);
    n_tests++; if (rdy !== 1'b1 || lat != 1) begin n_fail++; $display("FAIL wr_latency: ready %b lat %0d required 1/1", rdy, lat); end
    n_tests++; if (entrys[3] !== ew) begin n_fail++; $display("FAIL wr_entry3: got %h required %h", entrys[3], ew); end
    d = arr_diff();
    n_tests++; if (d != -1) begin n_fail++; $display("FAIL wr_array: idx %0d got %h required %h", d, entrys[d], mdl[d]); end
    @(negedge clk);
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_pulse: resp_valid got %b required 0", resp_valid); end
  endtask

  task automatic test_srch();
    do_req(OP_SRCH, '0, '0, 10'd5, 19'h12345, '0, lat, rdy);
    n_tests++; if (lat != 2 || resp_hit !== 1'b1 || resp_idx !== IW'(3)) begin
      n_fail++; $display("FAIL srch_hit: lat %0d hit %b idx %0d required 2/1/3", lat, resp_hit, resp_idx); end
    do_req(OP_SRCH, '0, '0, 10'd6, 19'h12345, '0, lat, rdy);
    n_tests++; if (resp_hit !== 1'b0 || resp_idx !== '0) begin
      n_fail++; $display("FAIL srch_asid_miss: hit %b idx %0d required 0/0", resp_hit, resp_idx); end
  endtask

  task automatic test_priority();
    do_req(OP_WR, IW'(2), mk(19'h0AAAA, 10'd7, 6'd12, 1'b0, 1'b1), '0, '0, '0, lat, rdy);
    do_req(OP_WR, IW'(1), mk(19'h0AAAA, 10'd7, 6'd12, 1'b0, 1'b1), '0, '0, '0, lat, rdy);
    do_req(OP_SRCH, '0, '0, 10'd7, 19'h0AAAA, '0, lat, rdy);
    n_tests++; if (resp_hit !== 1'b1 || resp_idx !== IW'(1)) begin
      n_fail++; $display("FAIL srch_lowest: hit %b idx %0d required 1/1", resp_hit, resp_idx); end
    do_req(OP_WR, IW'(0), mk(19'h12200, 10'd9, 6'd21, 1'b0, 1'b1), '0, '0, '0, lat, rdy);
    do_req(OP_SRCH, '0, '0, 10'd9, 19'h123FF, '0, lat, rdy);
    n_tests++; if (resp_hit !== 1'b1 || resp_idx !== IW'(0)) begin
      n_fail++; $display("FAIL srch_ps21: hit %b idx %0d required 1/0", resp_hit, resp_idx); end
    do_req(OP_SRCH, '0, '0, 10'd9, 19'h12400, '0, lat, rdy);
    n_tests++; if (resp_hit !== 1'b0) begin n_fail++; $display("FAIL srch_ps21_miss: hit %b required 0", resp_hit); end
  endtask

  task automatic test_rd();
    do_req(OP_RD, IW'(3), '0, '0, '0, '0, lat, rdy);
    n_tests++; if (lat != 1 || resp_entry !== exp_entry || exp_entry.vppn !== 19'h12345) begin
      n_fail++; $display("FAIL rd_valid: lat %0d got %h required %h", lat, resp_entry, exp_entry); end
    do_req(OP_WR, IW'(9), mk(19'h00777, 10'd3, 6'd12, 1'b1, 1'b0), '0, '0, '0, lat, rdy);
    do_req(OP_RD, IW'(9), '0, '0, '0, '0, lat, rdy);
    n_tests++; if (resp_entry !== '0) begin n_fail++; $display("FAIL rd_invalid_zero: got %h required 0", resp_entry); end
  endtask

  task automatic test_inv();
    do_req(OP_WR, IW'(4), mk(19'h00100, 10'd5, 6'd12, 1'b0, 1'b1), '0, '0, '0, lat, rdy);
    do_req(OP_WR, IW'(5), mk(19'h00101, 10'd5, 6'd12, 1'b1, 1'b1), '0, '0, '0, lat, rdy);
    do_req(OP_WR, IW'(6), mk(19'h00102, 10'd6, 6'd12, 1'b0, 1'b1), '0, '0, '0, lat, rdy);
    do_req(OP_WR, IW'(7), mk(19'h00103, 10'd5, 6'd21, 1'b0, 1'b1), '0, '0, '0, lat, rdy);
    do_req(OP_INV, '0, '0, 10'd5, '0, 5'd4, lat, rdy);
    n_tests++; if (lat != N + 1) begin n_fail++; $display("FAIL inv_latency: got %0d required %0d", lat, N + 1); end
    n_tests++; if ({entrys[7].e, entrys[6].e, entrys[5].e, entrys[4].e, entrys[3].e} !== 5'b01100) begin
      n_fail++; $display("FAIL inv_op4_bits: e[7:3] got %b required 01100",
                         {entrys[7].e, entrys[6].e, entrys[5].e, entrys[4].e, entrys[3].e}); end
    d = arr_diff();
    n_tests++; if (d != -1) begin n_fail++; $display("FAIL inv_array: idx %0d got %h required %h", d, entrys[d], mdl[d]); end
    do_req(OP_INV, '0, '0, 10'd5, '0, 5'd7, lat, rdy);
    n_tests++; if (lat != 1 || resp_inv_err !== 1'b1) begin
      n_fail++; $display("FAIL inv_err: lat %0d err %b required 1/1", lat, resp_inv_err); end
    d = arr_diff();
    n_tests++; if (d != -1) begin n_fail++; $display("FAIL inv_err_unchanged: idx %0d got %h required %h", d, entrys[d], mdl[d]); end
  endtask

  task automatic test_back_to_back();
    ew = mk(19'h33333, 10'd1, 6'd12, 1'b0, 1'b1);
    do_req(OP_WR, IW'(11), ew, '0, '0, '0, lat, rdy);
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: ready in RESP got %b required 0", req_ready); end
    do_req(OP_RD, IW'(11), '0, '0, '0, '0, lat, rdy);
    n_tests++; if (rdy !== 1'b1 || lat != 1 || resp_entry !== ew) begin
      n_fail++; $display("FAIL b2b_rd: ready %b lat %0d got %h required %h", rdy, lat, resp_entry, ew); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      do_req(OP_FILL, '0, mk(19'(k + 19'h40), 10'd2, 6'd12, 1'b0, 1'b1), '0, '0, '0, lat, rdy);
      d = arr_diff();
      n_tests++; if (lat != 1 || d != -1) begin
        n_fail++; $display("FAIL fill_%0d: lat %0d first diff idx %0d", k, lat, d); end
    end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [4:0] inv; tlb_entry_t t; logic [9:0] a; logic [18:0] v;
    for (int it = 0; it < 60; it++) begin
      op  = 3'($urandom_range(0, 4));
      if (op == OP_INV && $urandom_range(0, 2) != 0) op = OP_WR;
      inv = 5'($urandom_range(0, 7));
      t   = rand_entry();
      a   = ($urandom_range(0, 1) != 0) ? 10'd5 : 10'd6;
      v   = rand_entry().vppn;
      do_req(op, IW'($urandom_range(0, N - 1)), t, a, v, inv, lat, rdy);
      n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL rnd_lat[%0d] op %0d: got %0d required %0d", it, op, lat, exp_lat); end
      d = arr_diff();
      n_tests++; if (d != -1) begin n_fail++; $display("FAIL rnd_array[%0d] op %0d: idx %0d got %h required %h", it, op, d, entrys[d], mdl[d]); end
      if (op == OP_SRCH) begin
        n_tests++; if (resp_hit !== exp_hit || resp_idx !== exp_idx) begin
          n_fail++; $display("FAIL rnd_srch[%0d]: hit %b idx %0d required %b/%0d", it, resp_hit, resp_idx, exp_hit, exp_idx); end
      end else if (op == OP_RD) begin
        n_tests++; if (resp_entry !== exp_entry) begin
          n_fail++; $display("FAIL rnd_rd[%0d]: got %h required %h", it, resp_entry, exp_entry); end
      end else if (op == OP_INV) begin
        n_tests++; if (resp_inv_err !== exp_err) begin
          n_fail++; $display("FAIL rnd_inv_err[%0d]: got %b required %b", it, resp_inv_err, exp_err); end
      end
    end
  endtask

  task automatic test_reset_mid_inv();
    int pulses = 0;
    do_req(OP_WR, IW'(12), mk(19'h55555, 10'd5, 6'd12, 1'b1, 1'b1), '0, '0, '0, lat, rdy);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_INV; req_inv_op = 5'd2; req_asid = '0; req_vppn = '0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (N / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (entrys !== '0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL midinv_reset: entry12 %h ready %b valid %b required 0/1/0", entrys[12], req_ready, resp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < N + 4; c++) begin @(negedge clk); if (resp_valid === 1'b1) pulses++; end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL midinv_no_resp: pulses %0d required 0", pulses); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_idx = '0; req_entry = '0;
    req_asid = '0; req_vppn = '0; req_inv_op = '0;
    model_reset();
    test_reset();
    test_wr();
    test_srch();
    test_priority();
    test_rd();
    test_inv();
    test_back_to_back();
    test_fill();
    test_random();
    test_reset_mid_inv();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
